// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: after a start-up delay, writes a deterministic pattern over
// addresses 0..LAST_ADDR through a req/ack memory port. It then reads the range back
// and counts mismatches, and it exports a 16-bit status word for the 7-segment display.
// Optional feature macro: SDRAM_TEST_LFSR_EN. When it is defined, the pattern comes from a
// 16-bit Galois LFSR instead of address XOR pass_count.
module sdram_pattern_tester #(
    parameter int          ADDR_WIDTH  = 24,
    parameter int          DATA_WIDTH  = 16,
    parameter int unsigned LAST_ADDR   = 2**ADDR_WIDTH - 1,
    parameter int unsigned START_DELAY = 166000,
    parameter bit          CONTINUOUS  = 1'b1
) (
    input  logic                  dram_clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass_ok,
    output logic [15:0]           pass_count,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [15:0]           debug_number
);

    typedef enum logic [2:0] {IDLE, DELAY, WRITE, READ, DONE} state_t;

    localparam int REPS = (DATA_WIDTH >= 16) ? DATA_WIDTH / 16 : 1;
    localparam int DCW  = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

    // Whole copies of a 16-bit word, zero-extended or truncated to the data width
    function automatic logic [DATA_WIDTH-1:0] replicate16(input logic [15:0] v);
        logic [REPS*16-1:0] r;
        for (int i = 0; i < REPS; i++) r[i*16 +: 16] = v;
        return DATA_WIDTH'(r);
    endfunction

    state_t                state, state_next;
    logic [DCW-1:0]        delay_cnt;
    logic                  ack_fire, at_last, delay_done, begin_pass, mismatch;
    logic [15:0]           err_next;
    logic [DATA_WIDTH-1:0] first_wdata, next_wdata, expected_rdata;

    assign ack_fire   = mem_req && mem_ack;
    assign at_last    = (mem_addr == ADDR_WIDTH'(LAST_ADDR));
    assign delay_done = (delay_cnt == DCW'(START_DELAY));
    assign begin_pass = ((state == IDLE) && start) || ((state == DONE) && (CONTINUOUS || start));
    assign busy       = (state == DELAY) || (state == WRITE) || (state == READ);
    assign mismatch   = (mem_rdata != expected_rdata);
    assign err_next   = (mismatch && (error_count != 16'hFFFF)) ? error_count + 16'd1 : error_count;

`ifdef SDRAM_TEST_LFSR_EN
    logic [15:0] lfsr, lfsr_step, lfsr_seed;

    // Galois step (x^16+x^14+x^13+x^11+1, shift right) and per-pass seed, then pattern words
    always_comb begin
        lfsr_step      = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
        lfsr_seed      = pass_count | 16'd1;
        first_wdata    = replicate16(lfsr_seed);
        next_wdata     = replicate16(lfsr_step);
        expected_rdata = replicate16(lfsr);
    end

    // Reseed on entry to WRITE and READ, advance once per acknowledged transfer
    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'd0;
        end else if ((state == DELAY) && delay_done) begin
            lfsr <= lfsr_seed;
        end else if ((state == WRITE) && ack_fire) begin
            lfsr <= at_last ? lfsr_seed : lfsr_step;
        end else if ((state == READ) && ack_fire) begin
            lfsr <= lfsr_step;
        end
    end
`else
    // Address XOR replicated pass_count; pass_count is constant within a pass
    always_comb begin
        first_wdata    = replicate16(pass_count);
        next_wdata     = DATA_WIDTH'(mem_addr + 1'b1) ^ replicate16(pass_count);
        expected_rdata = DATA_WIDTH'(mem_addr) ^ replicate16(pass_count);
    end
`endif

    // State register
    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode; start is only honoured in IDLE or DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (begin_pass) state_next = DELAY;
            DELAY:   if (delay_done) state_next = WRITE;
            WRITE:   if (ack_fire && at_last) state_next = READ;
            READ:    if (ack_fire && at_last) state_next = DONE;
            DONE:    if (begin_pass) state_next = DELAY;
            default: state_next = IDLE;
        endcase
    end

    // Memory port, delay counter and pass statistics; port fields move only on ack or state change
    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset) begin
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            delay_cnt      <= '0;
            done           <= 1'b0;
            pass_ok        <= 1'b0;
            pass_count     <= 16'd0;
            error_count    <= 16'd0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (begin_pass) begin
                        error_count    <= 16'd0;
                        first_err_addr <= '0;
                        delay_cnt      <= '0;
                    end
                end
                DELAY: begin
                    if (delay_done) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= first_wdata;
                    end else begin
                        delay_cnt <= delay_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (ack_fire) begin
                        if (at_last) begin
                            mem_we   <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            mem_addr  <= mem_addr + 1'b1;
                            mem_wdata <= next_wdata;
                        end
                    end
                end
                READ: begin
                    if (ack_fire) begin
                        error_count <= err_next;
                        if (mismatch && (error_count == 16'd0)) first_err_addr <= mem_addr;
                        if (at_last) begin
                            mem_req    <= 1'b0;
                            mem_addr   <= '0;
                            done       <= 1'b1;
                            pass_count <= pass_count + 16'd1;
                            pass_ok    <= (err_next == 16'd0);
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Display word: pass count while clean, otherwise E plus the error count (clamped at EFFF)
    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset)                       debug_number <= 16'd0;
        else if (error_count == 16'd0)   debug_number <= pass_count;
        else if (error_count > 16'h0FFF) debug_number <= 16'hEFFF;
        else                             debug_number <= {4'hE, error_count[11:0]};
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb_sdram_pattern_tester: directed bench for sdram_pattern_tester with a small memory model.
// The bench follows SDRAM_TEST_LFSR_EN when computing expected pattern words.
module tb_sdram_pattern_tester;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          dram_clk = 1'b0;
    logic          reset, start, start_c;
    logic          mem_req, mem_we, mem_ack, busy, done, pass_ok;
    logic [AW-1:0] mem_addr, first_err_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   pass_count, error_count, debug_number;

    logic          mem_req_c, mem_we_c, mem_ack_c, busy_c, done_c, pass_ok_c;
    logic [AW-1:0] mem_addr_c, first_err_addr_c;
    logic [DW-1:0] mem_wdata_c, mem_rdata_c;
    logic [15:0]   pass_count_c, error_count_c, debug_number_c;

    int checks = 0;
    int errors = 0;

    logic [15:0]   mem_array [16];
    logic [15:0]   mem_c [16];
    logic [15:0]   wlog [16];
    logic [15:0]   w5 [3];
    logic          stuck_bit0 = 1'b0;
    logic          stall_en = 1'b0;
    int            stall_left = 0;
    logic          pending = 1'b0;
    logic [AW-1:0] held_addr;
    logic          held_we;
    logic [15:0]   held_wdata;
    int            wr_count = 0, rd_count = 0, stable_checks = 0, done_cnt_c = 0;
    logic [15:0]   model_pc = 16'd0;

    always #5 dram_clk = ~dram_clk;

    sdram_pattern_tester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDR(15),
                           .START_DELAY(3), .CONTINUOUS(1'b0)) dut (
        .dram_clk(dram_clk), .reset(reset), .start(start),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .pass_ok(pass_ok), .pass_count(pass_count), .error_count(error_count),
        .first_err_addr(first_err_addr), .debug_number(debug_number)
    );

    sdram_pattern_tester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDR(15),
                           .START_DELAY(3), .CONTINUOUS(1'b1)) dut_c (
        .dram_clk(dram_clk), .reset(reset), .start(start_c),
        .mem_req(mem_req_c), .mem_we(mem_we_c), .mem_addr(mem_addr_c), .mem_wdata(mem_wdata_c),
        .mem_ack(mem_ack_c), .mem_rdata(mem_rdata_c), .busy(busy_c), .done(done_c),
        .pass_ok(pass_ok_c), .pass_count(pass_count_c), .error_count(error_count_c),
        .first_err_addr(first_err_addr_c), .debug_number(debug_number_c)
    );

    assign mem_rdata   = mem_array[mem_addr] | {15'd0, stuck_bit0};
    assign mem_ack_c   = mem_req_c;
    assign mem_rdata_c = mem_c[mem_addr_c];

    // Reference model of pattern word k of a pass
    function automatic logic [15:0] exp_word(input int k, input logic [15:0] pc);
`ifdef SDRAM_TEST_LFSR_EN
        logic [15:0] l;
        l = pc | 16'd1;
        for (int i = 0; i < k; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        return l;
`else
        return 16'(k) ^ pc;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge dram_clk);
        #1;
    endtask

    // One-cycle start pulse to the stop-in-DONE instance (0) or the continuous instance (1)
    task automatic applyStimulus(input bit to_cont);
        if (to_cont) start_c = 1'b1;
        else         start   = 1'b1;
        tick();
        start   = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) tick();
        reset    = 1'b0;
        wr_count = 0;
        rd_count = 0;
        model_pc = 16'd0;
        tick();
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        while ((done !== 1'b1) && (cycles < budget)) begin
            tick();
            cycles++;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
    endtask

    // Main memory model: acks with optional random stalls, checks held fields and write data
    always @(negedge dram_clk) begin
        if (reset) begin
            mem_ack    = 1'b0;
            pending    = 1'b0;
            stall_left = 0;
        end else begin
            if (pending && mem_req) begin
                stable_checks++;
                checkOutput("held_addr", 32'(mem_addr), 32'(held_addr));
                checkOutput("held_we", 32'(mem_we), 32'(held_we));
                checkOutput("held_wdata", 32'(mem_wdata), 32'(held_wdata));
            end
            if (mem_req && (stall_left == 0)) begin
                mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
                if (mem_req) stall_left--;
            end
            if (mem_req && mem_ack) begin
                if (mem_we) begin
                    checkOutput("wr_addr", 32'(mem_addr), 32'(wr_count));
                    checkOutput("wr_data", 32'(mem_wdata), 32'(exp_word(wr_count, model_pc)));
                    mem_array[mem_addr] = mem_wdata;
                    if (wr_count < 16) wlog[wr_count] = mem_wdata;
                    wr_count++;
                end else begin
                    checkOutput("rd_addr", 32'(mem_addr), 32'(rd_count));
                    rd_count++;
                end
                stall_left = stall_en ? int'($urandom_range(0, 5)) : 0;
            end
            pending    = mem_req && !mem_ack;
            held_addr  = mem_addr;
            held_we    = mem_we;
            held_wdata = mem_wdata;
        end
    end

    // Continuous-instance memory: always ready, records the word written at address 5 per pass
    always @(negedge dram_clk) begin
        if (reset) begin
            done_cnt_c = 0;
        end else begin
            if (done_c) done_cnt_c++;
            if (mem_req_c && mem_we_c) begin
                mem_c[mem_addr_c] = mem_wdata_c;
                if ((mem_addr_c == 4'd5) && (done_cnt_c < 3)) w5[done_cnt_c] = mem_wdata_c;
            end
        end
    end

    // Directed sequence: clean pass, stuck bit, stalls, continuous passes, reset mid-read
    initial begin
        int          cyc;
        int          exp_errs;
        int          exp_first;
        logic [15:0] w;
        reset   = 1'b1;
        start   = 1'b0;
        start_c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_array[i] = 16'd0;
            mem_c[i]     = 16'd0;
            wlog[i]      = 16'd0;
        end
        for (int i = 0; i < 3; i++) w5[i] = 16'd0;

        $display("[TB] reset state");
        doReset();
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass_ok", 32'(pass_ok), 32'd0);
        checkOutput("rst_pass_count", 32'(pass_count), 32'd0);
        checkOutput("rst_error_count", 32'(error_count), 32'd0);
        checkOutput("rst_first_err", 32'(first_err_addr), 32'd0);
        checkOutput("rst_debug", 32'(debug_number), 32'd0);

        $display("[TB] clean pass");
        applyStimulus(1'b0);
        checkOutput("s1_busy_rise", 32'(busy), 32'd1);
        checkOutput("s1_req_in_delay", 32'(mem_req), 32'd0);
        repeat (3) tick();
        checkOutput("s1_req_late_delay", 32'(mem_req), 32'd0);
        tick();
        checkOutput("s1_first_req", 32'(mem_req), 32'd1);
        checkOutput("s1_first_we", 32'(mem_we), 32'd1);
        checkOutput("s1_first_addr", 32'(mem_addr), 32'd0);
        waitDone(200, cyc);
        checkOutput("s1_done_latency", 32'(cyc), 32'd32);
        checkOutput("s1_pass_ok", 32'(pass_ok), 32'd1);
        checkOutput("s1_pass_count", 32'(pass_count), 32'd1);
        checkOutput("s1_error_count", 32'(error_count), 32'd0);
        checkOutput("s1_busy_end", 32'(busy), 32'd0);
        checkOutput("s1_req_end", 32'(mem_req), 32'd0);
        checkOutput("s1_writes", 32'(wr_count), 32'd16);
        checkOutput("s1_reads", 32'(rd_count), 32'd16);
        checkOutput("s1_debug_lag", 32'(debug_number), 32'd0);
`ifdef SDRAM_TEST_LFSR_EN
        checkOutput("s1_wdata0", 32'(wlog[0]), 32'h0001);
        checkOutput("s1_wdata1", 32'(wlog[1]), 32'hB400);
        checkOutput("s1_wdata2", 32'(wlog[2]), 32'h5A00);
`else
        checkOutput("s1_wdata0", 32'(wlog[0]), 32'h0000);
        checkOutput("s1_wdata1", 32'(wlog[1]), 32'h0001);
        checkOutput("s1_wdata2", 32'(wlog[2]), 32'h0002);
`endif
        tick();
        checkOutput("s1_done_pulse", 32'(done), 32'd0);
        checkOutput("s1_debug", 32'(debug_number), 32'h0001);
        repeat (3) tick();
        checkOutput("s1_stays_idle", 32'(busy), 32'd0);
        checkOutput("s1_stays_noreq", 32'(mem_req), 32'd0);

        $display("[TB] bit0 stuck at 1 on reads");
        doReset();
        checkOutput("s2_pc_cleared", 32'(pass_count), 32'd0);
        stuck_bit0 = 1'b1;
`ifdef SDRAM_TEST_LFSR_EN
        exp_errs  = 0;
        exp_first = -1;
        for (int k = 0; k < 16; k++) begin
            w = exp_word(k, 16'd0);
            if (w[0] == 1'b0) begin
                if (exp_first < 0) exp_first = k;
                exp_errs++;
            end
        end
`else
        exp_errs  = 8;
        exp_first = 0;
`endif
        applyStimulus(1'b0);
        waitDone(200, cyc);
        stuck_bit0 = 1'b0;
        checkOutput("s2_error_count", 32'(error_count), 32'(exp_errs));
        checkOutput("s2_first_err", 32'(first_err_addr), 32'(exp_first));
        checkOutput("s2_pass_ok", 32'(pass_ok), 32'd0);
        checkOutput("s2_pass_count", 32'(pass_count), 32'd1);
        tick();
        checkOutput("s2_debug", 32'(debug_number), 32'({4'hE, 12'(exp_errs)}));

        $display("[TB] random ack stalls");
        doReset();
        stall_en      = 1'b1;
        stable_checks = 0;
        applyStimulus(1'b0);
        waitDone(1000, cyc);
        stall_en = 1'b0;
        checkOutput("s3_pass_ok", 32'(pass_ok), 32'd1);
        checkOutput("s3_pass_count", 32'(pass_count), 32'd1);
        checkOutput("s3_error_count", 32'(error_count), 32'd0);
        checkOutput("s3_writes", 32'(wr_count), 32'd16);
        checkOutput("s3_reads", 32'(rd_count), 32'd16);
        checkOutput("s3_stalls_seen", 32'(stable_checks > 0), 32'd1);
        tick();
        checkOutput("s3_debug", 32'(debug_number), 32'h0001);

        $display("[TB] reset during read phase");
        doReset();
        applyStimulus(1'b0);
        cyc = 0;
        while ((rd_count < 4) && (cyc < 200)) begin
            tick();
            cyc++;
        end
        checkOutput("s5_reached_read", 32'(rd_count >= 4), 32'd1);
        checkOutput("s5_req_before", 32'(mem_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("s5_req_async", 32'(mem_req), 32'd0);
        checkOutput("s5_busy_async", 32'(busy), 32'd0);
        checkOutput("s5_we_async", 32'(mem_we), 32'd0);
        checkOutput("s5_addr_async", 32'(mem_addr), 32'd0);
        checkOutput("s5_wdata_async", 32'(mem_wdata), 32'd0);
        checkOutput("s5_err_async", 32'(error_count), 32'd0);
        checkOutput("s5_debug_async", 32'(debug_number), 32'd0);
        tick();
        reset    = 1'b0;
        wr_count = 0;
        rd_count = 0;
        model_pc = 16'd0;
        tick();
        applyStimulus(1'b0);
        waitDone(200, cyc);
        checkOutput("s5_pass_ok", 32'(pass_ok), 32'd1);
        checkOutput("s5_pass_count", 32'(pass_count), 32'd1);
        checkOutput("s5_writes", 32'(wr_count), 32'd16);
        checkOutput("s5_reads", 32'(rd_count), 32'd16);

        $display("[TB] continuous passes");
        doReset();
        applyStimulus(1'b1);
        cyc = 0;
        while ((done_cnt_c < 3) && (cyc < 400)) begin
            tick();
            cyc++;
        end
        checkOutput("s4_three_dones", 32'(done_cnt_c), 32'd3);
        checkOutput("s4_pass_count", 32'(pass_count_c), 32'd3);
        checkOutput("s4_pass_ok", 32'(pass_ok_c), 32'd1);
        checkOutput("s4_restarted", 32'(busy_c), 32'd1);
`ifdef SDRAM_TEST_LFSR_EN
        checkOutput("s4_w5_pass1", 32'(w5[0]), 32'(exp_word(5, 16'd0)));
        checkOutput("s4_w5_pass2", 32'(w5[1]), 32'(exp_word(5, 16'd1)));
        checkOutput("s4_w5_pass3", 32'(w5[2]), 32'(exp_word(5, 16'd2)));
`else
        checkOutput("s4_w5_pass1", 32'(w5[0]), 32'h0005);
        checkOutput("s4_w5_pass2", 32'(w5[1]), 32'h0004);
        checkOutput("s4_w5_pass3", 32'(w5[2]), 32'h0007);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_pattern_tester.md
Name: sdram_pattern_tester

Overview:
Parametrised successor to the board's SDRAM bring-up heartbeat. After a configurable start-up delay it writes a deterministic pattern over an address range through a simple request/acknowledge memory port, reads the range back, and counts mismatches. It can repeat passes continuously. It exports a 16-bit status word for the 7-segment display.

Parameters:
ADDR_WIDTH, 24, width of mem_addr and of the address counter.
DATA_WIDTH, 16, width of the memory data words.
LAST_ADDR, 2**ADDR_WIDTH-1, final address tested; the range is 0..LAST_ADDR inclusive.
START_DELAY, 166000, idle cycles between start acceptance and the first write; 0 is legal.
CONTINUOUS, 1, 1 = start the next pass automatically after DONE; 0 = stop in DONE.

Ports:
dram_clk  in  1  sole clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a test from IDLE or DONE.
mem_req  out  1  request valid; held until acknowledged.
mem_we  out  1  1 = write, 0 = read; stable while mem_req is high.
mem_addr  out  ADDR_WIDTH  word address; stable while mem_req is high.
mem_wdata  out  DATA_WIDTH  write data; stable while mem_req is high.
mem_ack  in  1  request accepted this cycle; for reads, mem_rdata is valid in the same cycle.
mem_rdata  in  DATA_WIDTH  read data.
busy  out  1  high in DELAY, WRITE and READ.
done  out  1  one-cycle pulse at the end of each pass.
pass_ok  out  1  registered; 1 if the last completed pass had zero errors.
pass_count  out  16  completed passes; wraps.
error_count  out  16  mismatches in the current or last pass; saturates at 0xFFFF.
first_err_addr  out  ADDR_WIDTH  address of the first mismatch of the pass.
debug_number  out  16  display word.

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0 and the state is IDLE. mem_req drops immediately on reset assertion, even mid-transfer; the in-flight access is abandoned.
- States: IDLE, DELAY, WRITE, READ, DONE.
  - IDLE or DONE + start: clear error_count, first_err_addr and the delay counter, then enter DELAY.
  - DELAY: count START_DELAY cycles, then enter WRITE with addr=0. With START_DELAY=0, DELAY lasts exactly 1 cycle.
  - WRITE: mem_req=1, mem_we=1. Each cycle with mem_req&&mem_ack, the address increments on the next edge. mem_req stays high, so back-to-back transfers run at 1 per cycle. The ack at LAST_ADDR moves to READ with addr=0.
  - READ: mem_req=1, mem_we=0. On each ack, compare mem_rdata with expected(addr).
    - On mismatch, error_count increments, saturating at 0xFFFF.
    - If this is the first mismatch of the pass, latch first_err_addr.
    - The ack at LAST_ADDR goes to DONE. In that same cycle's update, fold in its comparison, then pulse done, increment pass_count and set pass_ok = (final error_count == 0).
  - DONE: if CONTINUOUS=1, the next cycle behaves as start (clear counters, DELAY). Otherwise wait for start.
- start while busy is ignored. start in the same cycle as the final ack is ignored; the CONTINUOUS rule governs what happens next.
- Pattern: expected(a) = a[DATA_WIDTH-1:0] XOR {DATA_WIDTH/16 copies of pass_count} (zero-extend or truncate when DATA_WIDTH is not a multiple of 16). Because pass_count is fixed within a pass, write and read use identical data.
- debug_number: pass_count while error_count==0; otherwise {4'hE, error_count[11:0]}, or 16'hEFFF if error_count > 0xFFF. debug_number is registered, so it updates 1 cycle after its sources change.
- mem_addr, mem_we and mem_wdata are registered. They change only on an acked edge or on a state change.

Optional Feature:
SDRAM_TEST_LFSR_EN: when defined, the pattern comes from a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, shift right, XOR mask 0xB400). The LFSR is seeded with pass_count|1 at the entry to WRITE and again at the entry to READ, and advances once per acked transfer. The pattern is the LFSR value replicated or truncated to DATA_WIDTH. When the macro is undefined, the address-XOR pattern above applies and no LFSR logic exists.

Test Plan:
- Setup: ADDR_WIDTH=4, LAST_ADDR=15, START_DELAY=3, CONTINUOUS=0, ideal memory model acking every cycle. start -> busy rises, first mem_req appears 4 cycles later. Expect 16 writes with wdata=addr, then 16 reads, then done pulse, pass_ok=1, pass_count=1, debug_number=0x0001.
- Memory model forces bit0 stuck at 1 on reads -> error_count=8, first_err_addr=0, pass_ok=0, debug_number=0xE008.
- Random ack stalls of 0-5 cycles -> mem_addr/mem_we/mem_wdata stable while mem_req is high and unacked; result same as the first scenario.
- CONTINUOUS=1, 3 passes -> three done pulses; pass-2 wdata at addr 5 = 0x0004; pass_count=3.
- Assert reset mid-READ -> mem_req low in the same cycle (asynchronous); all outputs 0; state IDLE; a later start runs a clean pass.
- With SDRAM_TEST_LFSR_EN defined, pass 0 (seed 1) -> first three write words 0x0001, 0xB400, 0x5A00; reads match; pass_ok=1.
